// File: rtl/reg_file_gen.sv
// rtl/reg_file_gen.sv - parameterised 2R1W register file with sweep-based clear
// Reset and clr_req both run a one-register-per-edge zeroing sweep; writes are dropped while it runs.
module reg_file_gen #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int AW      = $clog2(NREG),
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  input  logic            clr_req,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            busy,
  output logic            wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   cnt, cnt_nx;
  logic [XLEN-1:0] regs [NREG];
  logic            wr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == AW'(NREG - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy    = (state == CLEAR);
  assign wr_drop = WE3 & busy;
  assign wr_ok   = WE3 && !busy && !((ZERO_R0 != 0) && (A3 == '0));

  // Storage has no reset: the sweep is the only way contents get zeroed.
  always_ff @(posedge clk) begin
    if (busy)       regs[cnt] <= '0;
    else if (wr_ok) regs[A3]  <= WD3;
  end

  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   a,
    input logic            is_busy,
    input logic            wr_hit,
    input logic [XLEN-1:0] wd,
    input logic [XLEN-1:0] stored
  );
    if (is_busy)                          return '0;
    else if ((ZERO_R0 != 0) && (a == '0)) return '0;
    else if ((BYPASS != 0) && wr_hit)     return wd;
    else                                  return stored;
  endfunction

  always_comb begin
    RD1 = read_port(A1, busy, wr_ok && (A3 == A1), WD3, regs[A1]);
    RD2 = read_port(A2, busy, wr_ok && (A3 == A2), WD3, regs[A2]);
  end

endmodule

// File: tb/tb_reg_file_gen.sv
// tb/tb_reg_file_gen.sv - randomised check of reg_file_gen against a behavioural model
// Two instances share stimulus: one with same-cycle bypass, one without.
module tb_reg_file_gen;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   a1 = '0, a2 = '0, a3 = '0;
  logic [XLEN-1:0] wd = '0;
  logic            we = 1'b0, clr_req = 1'b0;

  logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic            busy_b, busy_n, drop_b, drop_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] model [NREG];
  int              sweep_left = NREG;

  reg_file_gen #(.XLEN(XLEN), .NREG(NREG), .ZERO_R0(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WD3(wd), .WE3(we),
    .clr_req(clr_req), .RD1(rd1_b), .RD2(rd2_b), .busy(busy_b), .wr_drop(drop_b)
  );

  reg_file_gen #(.XLEN(XLEN), .NREG(NREG), .ZERO_R0(1), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WD3(wd), .WE3(we),
    .clr_req(clr_req), .RD1(rd1_n), .RD2(rd2_n), .busy(busy_n), .wr_drop(drop_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a clear is just "NREG edges remaining", zeroing the next register each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) sweep_left = NREG;
    else if (sweep_left > 0) begin
      model[NREG - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (we && a3 != 0) model[a3] = wd;
      if (clr_req) sweep_left = NREG;
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (sweep_left > 0)            return '0;
    if (a == 0)                    return '0;
    if (byp && we && a3 == a)      return wd;
    return model[a];
  endfunction

  always @(negedge clk) begin
    check("busy_byp", {31'b0, busy_b}, {31'b0, sweep_left > 0});
    check("busy_nob", {31'b0, busy_n}, {31'b0, sweep_left > 0});
    check("drop_byp", {31'b0, drop_b}, {31'b0, we && sweep_left > 0});
    check("drop_nob", {31'b0, drop_n}, {31'b0, we && sweep_left > 0});
    check("rd1_byp", rd1_b, exp_rd(a1, 1'b1));
    check("rd2_byp", rd2_b, exp_rd(a2, 1'b1));
    check("rd1_nob", rd1_n, exp_rd(a1, 1'b0));
    check("rd2_nob", rd2_n, exp_rd(a2, 1'b0));
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_b && n < 100) begin
      step;
      n++;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    count_busy(n);
    check("reset_sweep_len", n, 32);
    a1 = 5'd17; a2 = 5'd31;
    @(negedge clk);
    check("rd1_after_reset", rd1_b, 32'h0);
    check("rd2_after_reset", rd2_b, 32'h0);
    step;

    we = 1'b1; a3 = 5'd9; wd = 32'h0000_00F4;
    step;
    we = 1'b0; a1 = 5'd9; a2 = 5'd9;
    @(negedge clk);
    check("wr_rd1_reg9", rd1_b, 32'h0000_00F4);
    check("wr_rd2_reg9", rd2_b, 32'h0000_00F4);
    step;

    we = 1'b1; a3 = 5'd5; wd = 32'h11;
    step;
    wd = 32'h6; a1 = 5'd5;
    @(negedge clk);
    check("bypass_on", rd1_b, 32'h6);
    check("bypass_off", rd1_n, 32'h11);
    step;
    we = 1'b0;
    @(negedge clk);
    check("nobyp_after_edge", rd1_n, 32'h6);
    step;

    we = 1'b1; a3 = 5'd0; wd = 32'hDEAD_BEEF; a1 = 5'd0;
    @(negedge clk);
    check("r0_read", rd1_b, 32'h0);
    check("r0_no_drop", {31'b0, drop_b}, 32'h0);
    step;
    we = 1'b0;
    @(negedge clk);
    check("r0_after", rd1_b, 32'h0);
    step;

    we = 1'b1; a3 = 5'd4; wd = 32'h1C;
    step;
    a3 = 5'd6; wd = 32'hA;
    step;
    a3 = 5'd7; wd = 32'h77; clr_req = 1'b1;
    step;
    clr_req = 1'b0; a3 = 5'd4; wd = 32'h99;
    @(negedge clk);
    check("clr_busy", {31'b0, busy_b}, 32'h1);
    check("clr_drop", {31'b0, drop_b}, 32'h1);
    n = 0;
    while (busy_b && n < 100) begin
      clr_req = (n == 5);
      step;
      n++;
    end
    clr_req = 1'b0; we = 1'b0;
    check("clr_sweep_len", n, 32);
    a1 = 5'd4; a2 = 5'd6;
    @(negedge clk);
    check("clr_reg4", rd1_b, 32'h0);
    check("clr_reg6", rd2_b, 32'h0);
    step;

    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    repeat (10) step;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy_b}, 32'h1);
    step;
    step;
    rst = 1'b0;
    count_busy(n);
    check("midrst_sweep_len", n, 32);

    repeat (3000) begin
      we      = ($urandom_range(0, 9) < 6);
      a3      = AW'($urandom_range(0, NREG - 1));
      a1      = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, NREG - 1));
      a2      = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, NREG - 1));
      wd      = $urandom;
      clr_req = ($urandom_range(0, 149) == 0);
      if (rst) rst = ($urandom_range(0, 1) == 0);
      else     rst = ($urandom_range(0, 799) == 0);
      step;
    end
    rst = 1'b0; we = 1'b0; clr_req = 1'b0;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
